// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Sequencer for a matrix-multiply datapath. It fetches one instruction at a
// time, decodes it, and drives the register file, the operand fetch unit and
// the compute array through the states FETCH, DECODE, LDA, LDB, EXEC, STORE,
// RETIRE and HALT. Every output is registered. Each output value is computed
// together with the next state, so it is valid for the whole cycle of the
// state it belongs to.
//
// Instruction format: opcode = INSTR[31:28], operand address A = INSTR[AW-1:0]
//   0x0 NOP, 0x1 LOADA, 0x2 LOADB, 0x3 MUL, 0x4 STORE, 0xF HALT, others = NOP
//
// Parameters
//   N     matrix dimension; LOADB reads N consecutive rows
//   REGN  register-file depth; address width AW = $clog2(REGN/2)
//
// Ports
//   CLK         clock, all state changes on the rising edge
//   RSTN        synchronous reset, active HIGH despite its name
//   INSTR       current instruction, valid in the DECODE cycle
//   COMP_DONE   one-cycle pulse from the compute array
//   MEM_ADDR    register-file address for reads and writes
//   MEM_RD      read strobe (MAT_IN valid the following cycle)
//   MEM_WR      write strobe for RESULT at MEM_ADDR
//   MATAB_MUX   1 = broadcast MAT_IN into all rows (matrix A)
//   SEQ_B       row index captured by the fetch unit for matrix B
//   COMP_START  one-cycle pulse that starts the compute array
//   DOUT_MUX    drives DATAOUT onto RESULT
//   DONE        one-cycle pulse that advances the program counter
//   HALTED      level, high while halted
// -----------------------------------------------------------------------------
module control_unit #(
    parameter int N    = 16,
    parameter int REGN = 512
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic [31:0]                   INSTR,
    input  logic                          COMP_DONE,
    output logic [$clog2(REGN/2)-1:0]     MEM_ADDR,
    output logic                          MEM_RD,
    output logic                          MEM_WR,
    output logic                          MATAB_MUX,
    output logic [$clog2(N)-1:0]          SEQ_B,
    output logic                          COMP_START,
    output logic                          DOUT_MUX,
    output logic                          DONE,
    output logic                          HALTED
);

    localparam int AW = $clog2(REGN/2);
    localparam int SW = $clog2(N);
    localparam int CW = $clog2(N+1);   // step counter must reach N

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOADA = 4'h1;
    localparam logic [3:0] OP_LOADB = 4'h2;
    localparam logic [3:0] OP_MUL   = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_LDA,
        S_LDB,
        S_EXEC,
        S_STORE,
        S_RETIRE,
        S_HALT
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_q;   // operand address latched in DECODE
    logic [CW-1:0] cnt;      // LDB row index k; LDA/EXEC "past first cycle" flag

    // Only the opcode and operand-address fields carry meaning here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^INSTR[27:AW];

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            state      <= S_FETCH;
            addr_q     <= '0;
            cnt        <= '0;
            MEM_ADDR   <= '0;
            MEM_RD     <= 1'b0;
            MEM_WR     <= 1'b0;
            MATAB_MUX  <= 1'b0;
            SEQ_B      <= '0;
            COMP_START <= 1'b0;
            DOUT_MUX   <= 1'b0;
            DONE       <= 1'b0;
            HALTED     <= 1'b0;
        end else begin
            // NOTE: these non-blocking defaults are overridden by later
            // assignments in the same block, so each state only names the
            // outputs it raises; SEQ_B is left out on purpose so it holds.
            MEM_ADDR   <= '0;
            MEM_RD     <= 1'b0;
            MEM_WR     <= 1'b0;
            MATAB_MUX  <= 1'b0;
            COMP_START <= 1'b0;
            DOUT_MUX   <= 1'b0;
            DONE       <= 1'b0;
            HALTED     <= 1'b0;

            case (state)
                S_FETCH: begin
                    state <= S_DECODE;
                end

                S_DECODE: begin
                    addr_q <= INSTR[AW-1:0];
                    cnt    <= '0;
                    case (INSTR[31:28])
                        OP_LOADA: begin
                            state    <= S_LDA;
                            MEM_RD   <= 1'b1;
                            MEM_ADDR <= INSTR[AW-1:0];
                        end
                        OP_LOADB: begin
                            state    <= S_LDB;
                            MEM_RD   <= 1'b1;
                            MEM_ADDR <= INSTR[AW-1:0];
                        end
                        OP_MUL: begin
                            state      <= S_EXEC;
                            COMP_START <= 1'b1;
                        end
                        OP_STORE: begin
                            state    <= S_STORE;
                            MEM_WR   <= 1'b1;
                            DOUT_MUX <= 1'b1;
                            MEM_ADDR <= INSTR[AW-1:0];
                        end
                        OP_HALT: begin
                            state  <= S_HALT;
                            HALTED <= 1'b1;
                        end
                        default: begin   // OP_NOP and all unused opcodes
                            state <= S_RETIRE;
                            DONE  <= 1'b1;
                        end
                    endcase
                end

                S_LDA: begin
                    if (cnt == '0) begin
                        // Read data arrives now; broadcast it next cycle.
                        cnt       <= CW'(1);
                        MATAB_MUX <= 1'b1;
                    end else begin
                        state <= S_RETIRE;
                        DONE  <= 1'b1;
                    end
                end

                S_LDB: begin
                    // Row k is read in cycle k and captured in cycle k+1,
                    // so reads and captures overlap over N+1 cycles.
                    if (cnt == CW'(N)) begin
                        state <= S_RETIRE;
                        DONE  <= 1'b1;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        SEQ_B <= cnt[SW-1:0];
                        if (int'(cnt) < N - 1) begin
                            MEM_RD   <= 1'b1;
                            MEM_ADDR <= addr_q + AW'(cnt) + AW'(1);  // wraps mod 2^AW
                        end
                    end
                end

                S_EXEC: begin
                    // A COMP_DONE coincident with COMP_START belongs to an
                    // earlier operation and is ignored.
                    if (cnt == '0) begin
                        cnt <= CW'(1);
                    end else if (COMP_DONE) begin
                        state <= S_RETIRE;
                        DONE  <= 1'b1;
                    end
                end

                S_STORE: begin
                    state <= S_RETIRE;
                    DONE  <= 1'b1;
                end

                S_RETIRE: begin
                    state <= S_FETCH;
                end

                S_HALT: begin
                    HALTED <= 1'b1;
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Self-checking bench for control_unit. A reference model expands every
// instruction into the list of per-cycle output values its semantics demand
// (FETCH, DECODE, body cycles, RETIRE) and the stimulus (INSTR, COMP_DONE)
// for each cycle. One stepping task compares the DUT outputs against the
// expected record every cycle. Directed programs are followed by
// hand-computed latency/address expectations; a randomized program with
// random resets and spurious COMP_DONE pulses follows.
// -----------------------------------------------------------------------------
module tb_control_unit;

    localparam int N    = 16;
    localparam int REGN = 512;
    localparam int AW   = $clog2(REGN/2);
    localparam int SW   = $clog2(N);

    localparam int K_FETCH  = 0;
    localparam int K_DECODE = 1;
    localparam int K_BODY   = 2;
    localparam int K_RETIRE = 3;
    localparam int K_HALT   = 4;
    localparam int K_LDB    = 5;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic [31:0]   INSTR;
    logic          COMP_DONE;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_RD;
    logic          MEM_WR;
    logic          MATAB_MUX;
    logic [SW-1:0] SEQ_B;
    logic          COMP_START;
    logic          DOUT_MUX;
    logic          DONE;
    logic          HALTED;

    control_unit #(.N(N), .REGN(REGN)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .INSTR      (INSTR),
        .COMP_DONE  (COMP_DONE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_RD     (MEM_RD),
        .MEM_WR     (MEM_WR),
        .MATAB_MUX  (MATAB_MUX),
        .SEQ_B      (SEQ_B),
        .COMP_START (COMP_START),
        .DOUT_MUX   (DOUT_MUX),
        .DONE       (DONE),
        .HALTED     (HALTED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic          rd, wr, matab;
        logic [SW-1:0] seq_b;
        logic          start, dmux, done, halted;
        logic [31:0]   instr;
        logic          cd_forced, cd_val;
        int            tag, kind, idx;
    } cyc_t;

    typedef struct {
        logic [31:0] instr;
        int          d;
        int          tag;
    } prog_t;

    cyc_t          q[$];
    prog_t         prog[$];
    logic [SW-1:0] m_seq;
    int            checks = 0;
    int            passed = 0;
    int            cyc    = 0;
    int            spur_pct;
    bit            arm_ldb5, arm_halt_end, rand_rst, after_rst;

    // Measurements for the directed programs (tags below 64).
    int            dec_cyc[64], done_cyc[64], rd_cyc[64], matab_cyc[64], cd_cyc[64];
    int            rd_cnt[64], wr_cnt[64], start_cnt[64], done_cnt[64], halted_cnt[64];
    logic [AW-1:0] rd_addr[64], wr_addr[64];
    logic [SW-1:0] seq_last[64];
    logic [AW-1:0] ldb_addrs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] pack_exp(input cyc_t c);
        return 64'({c.addr, c.rd, c.wr, c.matab, c.seq_b, c.start, c.dmux, c.done, c.halted});
    endfunction

    function automatic logic [63:0] pack_act();
        return 64'({MEM_ADDR, MEM_RD, MEM_WR, MATAB_MUX, SEQ_B, COMP_START, DOUT_MUX, DONE, HALTED});
    endfunction

    function automatic cyc_t idle(input int tag, input int kind);
        cyc_t c;
        c.addr = '0; c.rd = 0; c.wr = 0; c.matab = 0; c.seq_b = m_seq;
        c.start = 0; c.dmux = 0; c.done = 0; c.halted = 0;
        c.instr = $urandom; c.cd_forced = 0; c.cd_val = 0;
        c.tag = tag; c.kind = kind; c.idx = 0;
        return c;
    endfunction

    // Expand one instruction into its expected cycle-by-cycle behaviour.
    task automatic expand(input prog_t p);
        cyc_t          c;
        logic [AW-1:0] a;
        a = p.instr[AW-1:0];
        q.push_back(idle(p.tag, K_FETCH));
        c = idle(p.tag, K_DECODE); c.instr = p.instr; q.push_back(c);
        case (p.instr[31:28])
            4'h1: begin
                c = idle(p.tag, K_BODY); c.rd = 1; c.addr = a; q.push_back(c);
                c = idle(p.tag, K_BODY); c.matab = 1; q.push_back(c);
            end
            4'h2: begin
                for (int k = 0; k <= N; k++) begin
                    if (k >= 1) m_seq = SW'(k - 1);
                    c = idle(p.tag, K_LDB); c.idx = k;
                    if (k < N) begin c.rd = 1; c.addr = a + AW'(k); end
                    q.push_back(c);
                end
            end
            4'h3: begin
                for (int j = 0; j <= p.d; j++) begin
                    c = idle(p.tag, K_BODY); c.idx = j;
                    if (j == 0) c.start = 1;
                    else begin c.cd_forced = 1; c.cd_val = (j == p.d); end
                    q.push_back(c);
                end
            end
            4'h4: begin
                c = idle(p.tag, K_BODY); c.wr = 1; c.dmux = 1; c.addr = a; q.push_back(c);
            end
            4'hF: begin
                for (int h = 0; h < 100; h++) begin
                    c = idle(p.tag, K_HALT); c.halted = 1; c.idx = h; q.push_back(c);
                end
            end
            default: ;
        endcase
        if (p.instr[31:28] != 4'hF) begin
            c = idle(p.tag, K_RETIRE); c.done = 1; q.push_back(c);
        end
    endtask

    task automatic add(input logic [31:0] instr, input int d, input int tag);
        prog_t p;
        p.instr = instr; p.d = d; p.tag = tag;
        prog.push_back(p);
    endtask

    // One clock cycle: compare, measure, drive stimulus, advance.
    task automatic step();
        cyc_t c;
        logic rst;
        if (q.size() == 0) begin
            if (prog.size() == 0) add(32'h0, 1, 999);
            expand(prog.pop_front());
        end
        c = q.pop_front();

        if (after_rst) check("post_reset_zero", pack_act(), 64'h0);
        check("cycle_outputs", pack_act(), pack_exp(c));
        check("rd_wr_exclusive", 64'(MEM_RD & MEM_WR), 64'h0);

        if (c.tag < 64) begin
            if (c.kind == K_DECODE) dec_cyc[c.tag] = cyc;
            if (DONE) begin done_cyc[c.tag] = cyc; done_cnt[c.tag]++; end
            if (MEM_RD) begin
                rd_cnt[c.tag]++;
                if (rd_cnt[c.tag] == 1) begin rd_cyc[c.tag] = cyc; rd_addr[c.tag] = MEM_ADDR; end
                if (c.tag == 1) ldb_addrs.push_back(MEM_ADDR);
            end
            if (MATAB_MUX) matab_cyc[c.tag] = cyc;
            if (MEM_WR) begin wr_cnt[c.tag]++; wr_addr[c.tag] = MEM_ADDR; end
            if (COMP_START) start_cnt[c.tag]++;
            if (HALTED) halted_cnt[c.tag]++;
            if (c.cd_forced && c.cd_val) cd_cyc[c.tag] = cyc;
            seq_last[c.tag] = SEQ_B;
        end

        rst = 1'b0;
        if (arm_ldb5 && c.kind == K_LDB && c.idx == 5) begin rst = 1'b1; arm_ldb5 = 0; end
        if (arm_halt_end && c.kind == K_HALT && q.size() == 0) begin rst = 1'b1; arm_halt_end = 0; end
        if (rand_rst && $urandom_range(0, 199) == 0) rst = 1'b1;

        INSTR     = c.instr;
        COMP_DONE = c.cd_forced ? c.cd_val : ($urandom_range(1, 100) <= spur_pct);
        RSTN      = rst;
        @(posedge CLK);
        #1;
        cyc++;
        after_rst = rst;
        if (rst) begin
            q.delete();
            m_seq = '0;
        end
    endtask

    task automatic run_all();
        int guard;
        guard = 0;
        while ((q.size() > 0 || prog.size() > 0) && guard < 20000) begin
            step();
            guard++;
        end
        if (guard >= 20000) begin
            checks++;
            $display("FAIL drain_timeout: got %0d cycles expected under 20000", guard);
        end
    endtask

    function automatic logic [AW-1:0] ldb_at(input int i);
        return (ldb_addrs.size() > i) ? ldb_addrs[i] : 'x;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) begin
            dec_cyc[i] = -1; done_cyc[i] = -1; rd_cyc[i] = -1; matab_cyc[i] = -1; cd_cyc[i] = -1;
            rd_cnt[i] = 0; wr_cnt[i] = 0; start_cnt[i] = 0; done_cnt[i] = 0; halted_cnt[i] = 0;
            rd_addr[i] = 'x; wr_addr[i] = 'x; seq_last[i] = 'x;
        end
        m_seq = '0; arm_ldb5 = 0; arm_halt_end = 0; rand_rst = 0; after_rst = 0;

        // Reset for two edges; all outputs, SEQ_B included, must read 0.
        RSTN = 1'b1; INSTR = '0; COMP_DONE = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("reset_outputs", pack_act(), 64'h0);

        // Directed program; COMP_DONE is high in every cycle where it must be ignored.
        spur_pct = 100;
        add({4'h1, 20'h12345, 8'h10}, 0, 0);   // LOADA 0x10
        add({4'h2, 20'h0,     8'hF8}, 0, 1);   // LOADB 0xF8 (wraps)
        add({4'h3, 20'hABCDE, 8'h00}, 5, 2);   // MUL, COMP_DONE 5 cycles after COMP_START
        add({4'h4, 20'h0,     8'h3C}, 0, 3);   // STORE 0x3C
        add({4'h7, 28'h5A5A5A5},      0, 4);   // unused opcode -> NOP
        add(32'h0,                    0, 5);   // NOP
        run_all();

        check("loada_rd_addr",     64'(rd_addr[0]), 64'h10);
        check("loada_matab_next",  64'(matab_cyc[0] - rd_cyc[0]), 64'd1);
        check("loada_latency",     64'(done_cyc[0] - dec_cyc[0] + 1), 64'd4);
        check("loadb_reads",       64'(rd_cnt[1]), 64'd16);
        check("loadb_first_addr",  64'(ldb_at(0)), 64'hF8);
        check("loadb_wrap_addr",   64'(ldb_at(8)), 64'h00);
        check("loadb_last_addr",   64'(ldb_at(15)), 64'h07);
        check("loadb_seq_last",    64'(seq_last[1]), 64'd15);
        check("loadb_latency",     64'(done_cyc[1] - dec_cyc[1] + 1), 64'd19);
        check("mul_start_pulses",  64'(start_cnt[2]), 64'd1);
        check("mul_done_gap",      64'(done_cyc[2] - cd_cyc[2] + 1), 64'd2);
        check("mul_latency",       64'(done_cyc[2] - dec_cyc[2] + 1), 64'd8);
        check("store_writes",      64'(wr_cnt[3]), 64'd1);
        check("store_addr",        64'(wr_addr[3]), 64'h3C);
        check("store_latency",     64'(done_cyc[3] - dec_cyc[3] + 1), 64'd3);
        check("op7_latency",       64'(done_cyc[4] - dec_cyc[4] + 1), 64'd2);
        check("nop_latency",       64'(done_cyc[5] - dec_cyc[5] + 1), 64'd2);

        // Reset in LDB at k = 5, then HALT held for 100 cycles, then reset again.
        spur_pct = 25;
        arm_ldb5 = 1; arm_halt_end = 1;
        add({4'h2, 20'h0, 8'h40}, 0, 6);
        add({4'hF, 28'h0},        0, 50);
        add(32'h0,                0, 7);
        run_all();
        check("ldb_reads_before_reset", 64'(rd_cnt[6]), 64'd6);
        check("ldb_no_done",            64'(done_cnt[6]), 64'd0);
        check("halt_no_done",           64'(done_cnt[50]), 64'd0);
        check("halt_cycles",            64'(halted_cnt[50]), 64'd100);
        check("nop_after_halt_latency", 64'(done_cyc[7] - dec_cyc[7] + 1), 64'd2);

        // Randomized program with spurious COMP_DONE and occasional resets.
        rand_rst = 1;
        for (int i = 0; i < 80; i++)
            add({4'($urandom_range(0, 14)), 28'($urandom)}, $urandom_range(1, 8), 100 + i);
        run_all();
        rand_rst = 0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
